fifo_rd_serializer: RTL

- Downstream consumer of the synchronous show-ahead FIFO: reads one DATA_WIDTH word at a time and emits it as RATIO narrower beats on a valid/ready stream.
- Sits between the FIFO read port (empty/rden/rdata) and a narrow sink, such as a link or a byte-wide engine.
- Holds one word locally so the FIFO entry is freed on the load cycle.
- Sustains one beat per cycle with no bubble between words.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_rd_serializer.sv | 110 +++++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side serializer: state encoding and
// the helper that picks one output slice out of a held word.
package fifo_pkg;

  // Widest word the slice helper accepts; wider words are rejected at elaboration.
  localparam int SER_MAX_W = 512;

  typedef enum logic {S_EMPTY, S_ACTIVE} ser_state_t;

  // Returns the held word shifted so that slice idx sits in the low bits.
  // With msb_first set, idx 0 maps to the most significant slice.
  function automatic logic [SER_MAX_W-1:0] ser_slice(
    input logic [SER_MAX_W-1:0] word,
    input int unsigned          idx,
    input logic                 msb_first,
    input int unsigned          out_width,
    input int unsigned          ratio
  );
    int unsigned sel;
    sel = msb_first ? (ratio - 1 - idx) : idx;
    return word >> (sel * out_width);
  endfunction

endpackage

// File: rtl/fifo_rd_serializer.sv
// Pops one word at a time from a show-ahead FIFO and streams it out as
// RATIO narrow beats on a valid/ready interface, with no bubble between words.
module fifo_rd_serializer
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_WIDTH  = 8,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  empty_i,
  output logic                  rden_o,
  input  logic [DATA_WIDTH-1:0] rdata_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [OUT_WIDTH-1:0]  data_o,
  output logic                  last_o,
  output logic                  idle_o
);

  localparam int RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RATIO - 1);

  generate
    if ((OUT_WIDTH <= 0) || (DATA_WIDTH % OUT_WIDTH != 0) || (RATIO < 2)) begin : g_bad_ratio
      $error("fifo_rd_serializer: DATA_WIDTH must be a multiple of OUT_WIDTH with ratio >= 2");
    end
    if (DATA_WIDTH > SER_MAX_W) begin : g_bad_width
      $error("fifo_rd_serializer: DATA_WIDTH exceeds SER_MAX_W");
    end
  endgenerate

  ser_state_t            state, state_nxt;
  logic [DATA_WIDTH-1:0] word_buf, word_buf_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic                  hs;
  logic                  load;
  logic [SER_MAX_W-1:0]  slice_word;
  logic                  unused_slice_bits;

  assign valid_o = (state == S_ACTIVE);
  assign idle_o  = (state == S_EMPTY);
  assign last_o  = valid_o & (cnt == CNT_LAST);
  assign hs      = valid_o & ready_i;

  // A word is popped when nothing is held, or when the final beat of the held
  // word leaves this cycle; reset and an empty FIFO both block the pop.
  assign load   = rst_n & ~empty_i & (idle_o | (hs & last_o));
  assign rden_o = load;

  assign slice_word        = ser_slice(SER_MAX_W'(word_buf), 32'(cnt), MSB_FIRST != 0,
                                       OUT_WIDTH, RATIO);
  assign data_o            = slice_word[OUT_WIDTH-1:0];
  assign unused_slice_bits = ^slice_word[SER_MAX_W-1:OUT_WIDTH];

  // Next-state: load a new word, step through its beats, or fall back to empty.
  always_comb begin
    state_nxt    = state;
    word_buf_nxt = word_buf;
    cnt_nxt      = cnt;
    case (state)
      S_EMPTY: begin
        if (load) begin
          word_buf_nxt = rdata_i;
          cnt_nxt      = '0;
          state_nxt    = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (hs) begin
          if (!last_o) begin
            cnt_nxt = cnt + CNT_W'(1);
          end else if (load) begin
            word_buf_nxt = rdata_i;
            cnt_nxt      = '0;
          end else begin
            state_nxt = S_EMPTY;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = S_EMPTY;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register with synchronous reset; reset drops any word being sent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_EMPTY;
      word_buf <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      word_buf <= word_buf_nxt;
      cnt      <= cnt_nxt;
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rden_o && empty_i));

  a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (valid_o && !ready_i) |=> ($stable(data_o) && $stable(last_o)));

endmodule
